// File: rtl/cyq_disp_pkg.sv
// Shared types and constants for the key-scan / 7-segment display controller.
// Holds the debounce FSM states, history entry layout and segment patterns.
package cyq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } disp_state_t;

    localparam int NUM_DIGITS = 4;

    // Segment patterns, bit order gfedcba, active high.
    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef struct packed {
        logic       valid;
        logic [2:0] code;
    } hist_entry_t;

    function automatic logic [6:0] seg7_of(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = SEG7_0;
            3'd1:    seg = SEG7_1;
            3'd2:    seg = SEG7_2;
            3'd3:    seg = SEG7_3;
            3'd4:    seg = SEG7_4;
            3'd5:    seg = SEG7_5;
            3'd6:    seg = SEG7_6;
            default: seg = SEG7_7;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cyq_seg7_dec.sv
// Combinational decoder from a history entry to 7-segment pattern.
// Invalid entries blank the digit.
module cyq_seg7_dec
    import cyq_disp_pkg::*;
(
    input  logic       i_valid,
    input  logic [2:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG7_BLANK;
        if (i_valid) begin
            o_seg = seg7_of(i_code);
        end
    end

endmodule

// File: rtl/cyq_disp_scan_ctrl.sv
// Debounced 8-key priority encoder feeding a 4-digit history that is
// time-multiplexed onto a single 7-segment decoder.
module cyq_disp_scan_ctrl
    import cyq_disp_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EI,
    input  logic [7:0] I,
    output logic [6:0] SEG,
    output logic [3:0] DIG,
    output logic [2:0] CODE,
    output logic       VALID
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Bit 8 carries EI alongside the key lines; all load 1 (released) on reset.
    logic [8:0]        r_sync1;
    logic [8:0]        r_sync2;
    logic              w_any;
    logic [2:0]        w_code;

    disp_state_t       r_state;
    disp_state_t       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [2:0]        r_cand;
    logic [2:0]        w_cand_next;
    logic              w_commit;

    hist_entry_t       r_hist [NUM_DIGITS];
    logic [DIV_W-1:0]  r_div;
    logic [IDX_W-1:0]  r_idx;
    hist_entry_t       w_disp;
    logic [6:0]        w_seg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {EI, I};
            r_sync2 <= r_sync1;
        end
    end

    assign w_any = !r_sync2[8] && (r_sync2[7:0] != 8'hFF);

    // Later iterations override earlier ones, so the highest low index wins.
    always_comb begin
        w_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_sync2[i]) begin
                w_code = 3'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = DEBOUNCE;
                    w_cand_next  = w_code;
                    w_cnt_next   = '0;
                end
            end
            DEBOUNCE: begin
                if (!w_any || (w_code != r_cand)) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HELD: begin
                // A different key while held is deliberately ignored.
                if (!w_any) begin
                    w_state_next = RELEASE;
                    w_cnt_next   = '0;
                end
            end
            RELEASE: begin
                if (w_any) begin
                    w_state_next = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_hist[d] <= '0;
            end
            CODE  <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= w_commit;
            if (w_commit) begin
                r_hist[0] <= '{valid: 1'b1, code: r_cand};
                for (int d = 1; d < NUM_DIGITS; d++) begin
                    r_hist[d] <= r_hist[d-1];
                end
                CODE <= r_cand;
            end
        end
    end

    assign w_disp = r_hist[r_idx];

    cyq_seg7_dec u_seg7_dec (
        .i_valid (w_disp.valid),
        .i_code  (w_disp.code),
        .o_seg   (w_seg)
    );

    // Display reads the pre-edge history, so a commit shows up one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div <= '0;
            r_idx <= '0;
            DIG   <= 4'b1111;
            SEG   <= SEG7_BLANK;
        end else begin
            DIG <= ~(4'b0001 << r_idx);
            SEG <= w_seg;
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_idx <= r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cyq_disp_scan_ctrl.sv
// Randomised and directed bench for cyq_disp_scan_ctrl against a behavioural
// model of the synchroniser, debounce rules, history and digit scan.
module tb_cyq_disp_scan_ctrl;

    localparam int DEB  = 4;
    localparam int SDIV = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EI;
    logic [7:0] I;
    logic [6:0] SEG;
    logic [3:0] DIG;
    logic [2:0] CODE;
    logic       VALID;

    cyq_disp_scan_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EI    (EI),
        .I     (I),
        .SEG   (SEG),
        .DIG   (DIG),
        .CODE  (CODE),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int vcount = 0;

    logic [6:0] seg_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    // Reference model: pin history, debounced key state, history list, scan position.
    logic [8:0] m_s1, m_s2;
    bit         m_down;
    int         m_cand, m_run, m_rel;
    int         m_hv [4];
    int         m_hc [4];
    int         m_idx, m_div;
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic [2:0] e_code;
    logic       e_valid;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 9'h1FF; m_s2 = 9'h1FF;
        m_down = 0; m_cand = 0; m_run = 0; m_rel = 0;
        for (int d = 0; d < 4; d++) begin m_hv[d] = 0; m_hc[d] = 0; end
        m_idx = 0; m_div = 0;
        e_seg = 7'h00; e_dig = 4'hF; e_code = 3'd0; e_valid = 1'b0;
    endtask

    // Advance the model by one clock using the pre-edge pin values.
    task automatic model_step();
        int k;
        bit commit;
        k = -1;
        commit = 0;
        if (!m_s2[8]) for (int b = 0; b < 8; b++) if (!m_s2[b]) k = b;
        e_dig = 4'hF ^ (4'h1 << m_idx);
        e_seg = (m_hv[m_idx] != 0) ? seg_tab[m_hc[m_idx]] : 7'h00;
        if (!m_down) begin
            // m_run = number of consecutive matching observations so far
            if (m_run == 0) begin
                if (k >= 0) begin m_cand = k; m_run = 1; end
            end else if (k < 0 || k != m_cand) begin
                m_run = 0;
            end else if (m_run == DEB) begin
                commit = 1; m_down = 1; m_run = 0; m_rel = 0;
            end else begin
                m_run++;
            end
        end else begin
            if (k >= 0) m_rel = 0;
            else if (m_rel == 0) m_rel = 1;
            else if (m_rel == DEB) begin m_down = 0; m_rel = 0; end
            else m_rel++;
        end
        if (commit) begin
            for (int d = 3; d > 0; d--) begin m_hv[d] = m_hv[d-1]; m_hc[d] = m_hc[d-1]; end
            m_hv[0] = 1; m_hc[0] = m_cand;
            e_code = 3'(m_cand);
        end
        e_valid = commit;
        m_div++;
        if (m_div == SDIV) begin m_div = 0; m_idx = (m_idx + 1) % 4; end
        m_s2 = m_s1;
        m_s1 = {EI, I};
    endtask

    task automatic tick();
        if (!RST) model_step();
        @(posedge CLK);
        @(negedge CLK);
        check("SEG", 32'(SEG), 32'(e_seg));
        check("DIG", 32'(DIG), 32'(e_dig));
        check("CODE", 32'(CODE), 32'(e_code));
        check("VALID", 32'(VALID), 32'(e_valid));
        if (VALID) vcount++;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_seg"}, 32'(SEG), 32'h00);
        check({tag, "_dig"}, 32'(DIG), 32'hF);
        check({tag, "_code"}, 32'(CODE), 32'h0);
        check({tag, "_valid"}, 32'(VALID), 32'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check_reset_outs("rst_async");
        model_reset();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic hold(input logic [7:0] pins, input int n);
        I = pins;
        repeat (n) tick();
    endtask

    initial begin
        int n, seen, j;
        logic [7:0] p;
        int codes [5] = '{1, 2, 3, 4, 7};
        logic [6:0] exp_hist [4] = '{7'h07, 7'h66, 7'h4F, 7'h5B};

        RST = 1'b1; EI = 1'b0; I = 8'hFF;
        model_reset();
        @(negedge CLK);
        check_reset_outs("reset");
        tick();
        RST = 1'b0;

        // Idle scan: each digit selected for two cycles, blank, no VALID.
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("scan_dig", 32'(DIG), 32'(4'hF ^ (4'h1 << (i / 2))));
            check("scan_blank", 32'(SEG), 32'h0);
        end
        check("idle_no_valid", vcount, 0);

        // Single key 5: latency from the sampling edge and displayed value.
        vcount = 0;
        I = 8'hDF;
        n = 0;
        while (!VALID && n < 30) begin tick(); n++; end
        check("valid_latency", n - 1, DEB + 2);
        check("code5", 32'(CODE), 32'd5);
        seen = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (DIG == 4'b1110) begin seen++; check("seg5_dig0", 32'(SEG), 32'h6D); end
        end
        check("seen_dig0", seen > 0, 1);
        check("one_pulse5", vcount, 1);
        hold(8'hFF, 12);

        // Two-cycle glitch must not commit.
        vcount = 0;
        hold(8'hF7, 2);
        hold(8'hFF, 10);
        check("glitch_no_valid", vcount, 0);

        // Simultaneous keys 2 and 6: higher index wins.
        hold(8'hBB, 12);
        check("prio_code6", 32'(CODE), 32'd6);
        hold(8'hFF, 12);

        // Sequence 1,2,3,4,7 pushes the oldest out of the history.
        foreach (codes[c]) begin
            p = 8'h01 << codes[c];
            hold(~p, 10);
            hold(8'hFF, 10);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            j = -1;
            for (int d = 0; d < 4; d++) if (!DIG[d]) j = d;
            if (j >= 0) check("hist_digit", 32'(SEG), 32'(exp_hist[j]));
        end

        // EI high while holding key 4 acts as a release, then one re-commit.
        hold(8'hEF, 10);
        vcount = 0;
        EI = 1'b1;
        repeat (10) tick();
        EI = 1'b0;
        repeat (12) tick();
        check("ei_recommit_cnt", vcount, 1);
        check("ei_code4", 32'(CODE), 32'd4);
        hold(8'hFF, 12);

        // Reset in the middle of debouncing key 0.
        hold(8'hFE, 4);
        vcount = 0;
        do_reset();
        check("rst_no_valid", vcount, 0);
        repeat (12) tick();
        check("rst_redebounce", vcount, 1);
        check("rst_code0", 32'(CODE), 32'd0);
        hold(8'hFF, 12);

        // Random segments of held patterns, EI toggles and occasional resets.
        for (int s = 0; s < 160; s++) begin
            n = $urandom_range(0, 9);
            if (n < 3) p = 8'hFF;
            else if (n < 7) p = ~(8'h01 << $urandom_range(0, 7));
            else p = 8'($urandom);
            EI = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) do_reset();
            hold(p, $urandom_range(1, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
